// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
// The fetch stage is the master: it issues req/addr and receives ack/rdata.
interface fetch_stage_if;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ack;
   logic [31:0] imem_rdata;

   modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
   modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// IF stage and IF/ID register: req/ack fetch with a one-word skid buffer,
// delay-slot redirect from the decode stage and branch-likely annulment.
module fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000
) (
   input  logic               clk,
   input  logic               rst_n,
   fetch_stage_if.master      imem,
   input  logic               stall_D,
   input  logic [1:0]         npc_sel_D,
   input  logic               br_taken_D,
   input  logic               likely_D,
   input  logic [31:0]        ra_D,
   output logic [31:0]        instr_D,
   output logic [31:0]        pc_D,
   output logic [31:0]        pc8_D,
   output logic               valid_D
);

   typedef enum logic [0:0] {
      S_REQ  = 1'b0,
      S_FULL = 1'b1
   } state_t;

   function automatic logic [31:0] branch_target(input logic [31:0] pc4, input logic [15:0] imm);
      return pc4 + {{14{imm[15]}}, imm, 2'b00};
   endfunction

   function automatic logic [31:0] jump_target(input logic [31:0] pc4, input logic [25:0] idx);
      return {pc4[31:28], idx, 2'b00};
   endfunction

   state_t      state_r, state_nxt_s;
   logic        req_r;
   logic [31:0] pc_f_r;
   logic [31:0] buf_r;
   logic [31:0] instr_d_r;
   logic [31:0] pc_d_r;
   logic        valid_d_r;
   logic        redir_pend_r;
   logic        annul_pend_r;
   logic [31:0] redir_tgt_r;

   logic        accept_s, live_s, taken_s, annul_ev_s, annul_now_s;
   logic        avail_s, deliver_s, skid_load_s;
   logic [31:0] pc4_d_s, target_s, next_pc_s, word_s;

   // Decode-stage redirect/annul evaluation and delivery qualification.
   always_comb begin
      accept_s   = !valid_d_r || !stall_D;
      live_s     = valid_d_r && !stall_D;
      pc4_d_s    = pc_d_r + 32'd4;
      taken_s    = 1'b0;
      annul_ev_s = 1'b0;
      target_s   = pc4_d_s;
      case (npc_sel_D)
         2'b01: begin
            taken_s    = live_s && br_taken_D;
            annul_ev_s = live_s && likely_D && !br_taken_D;
            target_s   = branch_target(pc4_d_s, instr_d_r[15:0]);
         end
         2'b10: begin
            taken_s  = live_s;
            target_s = ra_D;
         end
         2'b11: begin
            taken_s  = live_s;
            target_s = jump_target(pc4_d_s, instr_d_r[25:0]);
         end
         default: begin
            taken_s  = 1'b0;
            target_s = pc4_d_s;
         end
      endcase
      avail_s     = ((state_r == S_REQ) && req_r && imem.imem_ack) || (state_r == S_FULL);
      deliver_s   = avail_s && accept_s;
      word_s      = (state_r == S_FULL) ? buf_r : imem.imem_rdata;
      annul_now_s = annul_ev_s || annul_pend_r;
      if (taken_s) begin
         next_pc_s = target_s;
      end else if (redir_pend_r) begin
         next_pc_s = redir_tgt_r;
      end else begin
         next_pc_s = pc_f_r + 32'd4;
      end
   end

   // Fetch FSM next state; a word acked while decode is blocked goes to the skid buffer.
   always_comb begin
      state_nxt_s = state_r;
      skid_load_s = 1'b0;
      case (state_r)
         S_REQ: begin
            if (req_r && imem.imem_ack && !accept_s) begin
               state_nxt_s = S_FULL;
               skid_load_s = 1'b1;
            end else begin
               state_nxt_s = S_REQ;
            end
         end
         S_FULL: begin
            if (accept_s) begin
               state_nxt_s = S_REQ;
            end else begin
               state_nxt_s = S_FULL;
            end
         end
         default: begin
            state_nxt_s = S_REQ;
         end
      endcase
   end

   // FSM state, registered request and skid buffer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_REQ;
         req_r   <= 1'b0;
         buf_r   <= 32'h0000_0000;
      end else begin
         state_r <= state_nxt_s;
         req_r   <= (state_nxt_s == S_REQ);
         if (skid_load_s) begin
            buf_r <= imem.imem_rdata;
         end
      end
   end

   // PC_F, IF/ID register and pending delay-slot redirect/annul.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_f_r       <= RESET_PC;
         instr_d_r    <= 32'h0000_0000;
         pc_d_r       <= RESET_PC;
         valid_d_r    <= 1'b0;
         redir_pend_r <= 1'b0;
         annul_pend_r <= 1'b0;
         redir_tgt_r  <= RESET_PC;
      end else if (deliver_s) begin
         pc_d_r       <= pc_f_r;
         instr_d_r    <= annul_now_s ? 32'h0000_0000 : word_s;
         valid_d_r    <= !annul_now_s;
         pc_f_r       <= next_pc_s;
         redir_pend_r <= 1'b0;
         annul_pend_r <= 1'b0;
      end else begin
         // Nothing to deliver: a live instruction in D leaves and a bubble follows.
         if (live_s) begin
            instr_d_r <= 32'h0000_0000;
            valid_d_r <= 1'b0;
         end
         if (taken_s) begin
            redir_pend_r <= 1'b1;
            redir_tgt_r  <= target_s;
         end
         if (annul_ev_s) begin
            annul_pend_r <= 1'b1;
         end
      end
   end

   assign imem.imem_req  = req_r;
   assign imem.imem_addr = pc_f_r;
   assign instr_D        = instr_d_r;
   assign pc_D           = pc_d_r;
   assign valid_D        = valid_d_r;
   assign pc8_D          = pc_d_r + 32'd8;

endmodule
